// File: rtl/mfp_ahb_botif.sv
// AHB-Lite slave bridging the bot: status snapshot, control byte,
// update handshake (IDLE/PEND/ACK). Optional: MFP_BOTIF_ERR_RESP_EN.
// Ports: HCLK/SI_Reset, AHB slave (HSEL..HREADY in; HRDATA,
// HREADYOUT, HRESP out), bot side (IO_BotInfo, IO_BotUpdt_Sync in;
// IO_BotCtrl, IO_INT_ACK out).
module mfp_ahb_botif (
  input  logic        HCLK,
  input  logic        SI_Reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  input  logic [31:0] IO_BotInfo,
  input  logic        IO_BotUpdt_Sync,
  output logic [7:0]  IO_BotCtrl,
  output logic        IO_INT_ACK
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PEND = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [1:0] OFF_INFO = 2'd0;
  localparam logic [1:0] OFF_CTRL = 2'd1;
  localparam logic [1:0] OFF_STAT = 2'd2;
  localparam logic [1:0] OFF_ACK  = 2'd3;

  logic        dv_q;
  logic        wr_q;
  logic [1:0]  off_q;
  logic [1:0]  lane_q;
  logic [2:0]  size_q;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [31:0] info_q, info_d;
  logic [1:0]  st_q, st_d;
  logic        prev_q;
  logic        ack_q;
  logic        addr_take;
  logic        bad;
  logic        rd_en;
  logic        wr_en;
  logic        rise;
  logic [31:0] rdata;
  logic        unused_ok;

  assign unused_ok = ^{HADDR[31:4], HWDATA[31:8]};

  // INFO and STAT have even offsets: writes to them are illegal.
  assign bad   = dv_q & ((size_q > 3'd2) | (wr_q & ~off_q[0]));
  assign rd_en = dv_q & ~wr_q & ~bad;
  assign wr_en = dv_q & wr_q & ~bad;
  assign rise  = IO_BotUpdt_Sync & ~prev_q;

`ifdef MFP_BOTIF_ERR_RESP_EN
  logic err2_q;

  // First error cycle stalls the bus; its address phase is dropped.
  assign addr_take = HSEL & HTRANS[1] & HREADY & ~bad;
  assign HREADYOUT = ~bad;
  assign HRESP     = bad | err2_q;

  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) err2_q <= 1'b0;
    else          err2_q <= bad;
  end
`else
  assign addr_take = HSEL & HTRANS[1] & HREADY;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (rd_en) begin
      unique case (off_q)
        OFF_INFO: rdata = info_q;
        OFF_CTRL: rdata = {24'h0, ctrl_q};
        OFF_STAT: rdata = {30'h0, ack_q, st_q == ST_PEND};
        OFF_ACK:  rdata = '0;
      endcase
    end
  end

  assign HRDATA     = rdata;
  assign IO_BotCtrl = ctrl_q;
  assign IO_INT_ACK = ack_q;

  always_comb begin
    st_d   = st_q;
    info_d = info_q;
    ctrl_d = ctrl_q;
    // Only the lane holding bits [7:0] may update CTRL.
    if (wr_en && off_q == OFF_CTRL &&
        (size_q == 3'd2 || lane_q == 2'd0))
      ctrl_d = HWDATA[7:0];
    unique case (st_q)
      ST_IDLE: begin
        if (rise) begin
          st_d   = ST_PEND;
          info_d = IO_BotInfo;
        end
      end
      ST_PEND: begin
        if (wr_en && off_q == OFF_ACK && HWDATA[0])
          st_d = ST_ACK;
      end
      ST_ACK: begin
        if (!IO_BotUpdt_Sync) st_d = ST_IDLE;
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      dv_q   <= 1'b0;
      wr_q   <= 1'b0;
      off_q  <= 2'd0;
      lane_q <= 2'd0;
      size_q <= 3'd0;
    end else begin
      dv_q <= addr_take;
      if (addr_take) begin
        wr_q   <= HWRITE;
        off_q  <= HADDR[3:2];
        lane_q <= HADDR[1:0];
        size_q <= HSIZE;
      end
    end
  end

  // The update line is low whenever ACK exits, so prev_q is 0 then.
  always_ff @(posedge HCLK or posedge SI_Reset) begin
    if (SI_Reset) begin
      ctrl_q <= 8'h00;
      info_q <= '0;
      st_q   <= ST_IDLE;
      prev_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      info_q <= info_d;
      st_q   <= st_d;
      prev_q <= IO_BotUpdt_Sync;
      ack_q  <= (st_d == ST_ACK);
    end
  end

endmodule

// File: tb/tb_mfp_ahb_botif.sv
// Bench for mfp_ahb_botif: directed table, reset corners,
// random traffic against a behavioural model.
module tb_mfp_ahb_botif;

  logic        HCLK = 1'b0;
  logic        SI_Reset = 1'b1;
  logic        HSEL = 1'b0;
  logic [31:0] HADDR = '0;
  logic [1:0]  HTRANS = 2'b00;
  logic        HWRITE = 1'b0;
  logic [2:0]  HSIZE = 3'd2;
  logic [31:0] HWDATA = '0;
  logic        HREADY = 1'b1;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] IO_BotInfo = '0;
  logic        IO_BotUpdt_Sync = 1'b0;
  logic [7:0]  IO_BotCtrl;
  logic        IO_INT_ACK;

  mfp_ahb_botif dut (
    .HCLK(HCLK), .SI_Reset(SI_Reset), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
    .HWDATA(HWDATA), .HREADY(HREADY), .HRDATA(HRDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .IO_BotInfo(IO_BotInfo),
    .IO_BotUpdt_Sync(IO_BotUpdt_Sync), .IO_BotCtrl(IO_BotCtrl),
    .IO_INT_ACK(IO_INT_ACK)
  );

  always #5 HCLK = ~HCLK;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model: pending data phase plus register file.
  logic        m_dv, m_wr, m_prev, m_err2;
  logic [1:0]  m_off, m_lane;
  logic [2:0]  m_sz;
  logic [7:0]  m_ctrl;
  logic [31:0] m_info;
  int          m_st; // 0 idle, 1 waiting for ack, 2 acked

  logic [31:0] s_rdata;
  logic [7:0]  s_ctrl;
  logic        s_ack, s_rdy, s_resp;

  task automatic model_reset();
    m_dv = 0; m_wr = 0; m_off = 0; m_lane = 0; m_sz = 0;
    m_ctrl = 8'h00; m_info = '0; m_st = 0; m_prev = 0; m_err2 = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input logic sel, input logic [1:0] tr,
                      input logic [31:0] a, input logic wr,
                      input logic [2:0] sz, input logic [31:0] wd,
                      input logic sync, input logic [31:0] info,
                      input logic rdy);
    logic bad, rd, take, erdy, eresp;
    logic [31:0] er;
    int nst;
    @(negedge HCLK);
    HSEL = sel; HTRANS = tr; HADDR = a; HWRITE = wr; HSIZE = sz;
    HWDATA = wd; IO_BotUpdt_Sync = sync; IO_BotInfo = info;
    HREADY = rdy;
    #1;
    s_rdata = HRDATA; s_ctrl = IO_BotCtrl; s_ack = IO_INT_ACK;
    s_rdy = HREADYOUT; s_resp = HRESP;
    bad = m_dv && (m_sz > 3'd2 || (m_wr && (m_off == 0 || m_off == 2)));
    rd = m_dv && !m_wr && !bad;
    er = '0;
    if (rd) begin
      if (m_off == 0) er = m_info;
      else if (m_off == 1) er = {24'h0, m_ctrl};
      else if (m_off == 2) er = {30'h0, m_st == 2, m_st == 1};
    end
`ifdef MFP_BOTIF_ERR_RESP_EN
    erdy = !bad; eresp = bad || m_err2;
`else
    erdy = 1'b1; eresp = 1'b0;
`endif
    chk("model_hrdata", s_rdata, er);
    chk("model_ctrl", {24'h0, s_ctrl}, {24'h0, m_ctrl});
    chk("model_int_ack", {31'h0, s_ack}, {31'h0, m_st == 2});
    chk("model_hreadyout", {31'h0, s_rdy}, {31'h0, erdy});
    chk("model_hresp", {31'h0, s_resp}, {31'h0, eresp});
    @(posedge HCLK);
    nst = m_st;
    if (m_dv && m_wr && !bad) begin
      if (m_off == 1 && (m_sz == 2 || m_lane == 0)) m_ctrl = wd[7:0];
      if (m_off == 3 && wd[0] && m_st == 1) nst = 2;
    end
    if (m_st == 0 && sync && !m_prev) begin
      nst = 1;
      m_info = info;
    end
    if (m_st == 2 && !sync) nst = 0;
    m_st = nst;
    m_prev = sync;
    take = sel && tr[1] && rdy;
`ifdef MFP_BOTIF_ERR_RESP_EN
    if (bad) take = 1'b0;
    m_err2 = bad;
`endif
    m_dv = take;
    if (take) begin
      m_wr = wr; m_off = a[3:2]; m_lane = a[1:0]; m_sz = sz;
    end
  endtask

  task automatic rst_check(input string nm);
    chk({nm, "_ack"}, {31'h0, IO_INT_ACK}, 32'h0);
    chk({nm, "_ctrl"}, {24'h0, IO_BotCtrl}, 32'h0);
    chk({nm, "_hrdata"}, HRDATA, 32'h0);
    chk({nm, "_rdy_resp"}, {30'h0, HREADYOUT, HRESP}, 32'h2);
  endtask

  typedef struct {
    logic        sel;
    logic [3:0]  a;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic        sync;
    logic [31:0] info;
    logic [31:0] e_rd;
    logic [7:0]  e_ctrl;
    logic        e_ack;
    logic        e_rdy;
    logic        e_resp;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic sel, input logic [3:0] a,
                     input logic wr, input logic [2:0] sz,
                     input logic [31:0] wd, input logic sync,
                     input logic [31:0] info, input logic [31:0] e_rd,
                     input logic [7:0] e_ctrl, input logic e_ack,
                     input logic e_rdy, input logic e_resp);
    vec_t v;
    v.sel = sel; v.a = a; v.wr = wr; v.sz = sz; v.wd = wd;
    v.sync = sync; v.info = info; v.e_rd = e_rd; v.e_ctrl = e_ctrl;
    v.e_ack = e_ack; v.e_rdy = e_rdy; v.e_resp = e_resp;
    tv.push_back(v);
  endtask

`ifdef MFP_BOTIF_ERR_RESP_EN
  localparam logic E1_RDY = 1'b0, E1_RESP = 1'b1;
  localparam logic E2_RDY = 1'b1, E2_RESP = 1'b1;
`else
  localparam logic E1_RDY = 1'b1, E1_RESP = 1'b0;
  localparam logic E2_RDY = 1'b1, E2_RESP = 1'b0;
`endif

  localparam logic [31:0] I1 = 32'h1234_5678;
  localparam logic [31:0] I2 = 32'hFFFF_0000;

  logic        r_sync;
  logic [31:0] r_wd;
  logic [2:0]  r_sz;
  logic [3:0]  r_a;

  initial begin
    // sel a wr sz wd sync info | rdata ctrl ack rdy resp
    add(1, 4'h4, 0, 2, 0, 0, 0,        0,  8'h00, 0, 1, 0);
    add(0, 4'h0, 0, 2, 0, 0, 0,        0,  8'h00, 0, 1, 0);
    add(1, 4'h4, 1, 2, 0, 0, 0,        0,  8'h00, 0, 1, 0);
    add(1, 4'h4, 0, 2, 32'hA5, 0, 0,   0,  8'h00, 0, 1, 0);
    add(0, 4'h0, 0, 2, 0, 0, 0,        32'hA5, 8'hA5, 0, 1, 0);
    add(1, 4'h5, 1, 0, 0, 0, 0,        0,  8'hA5, 0, 1, 0);
    add(1, 4'h4, 0, 2, 32'h3C00, 0, 0, 0,  8'hA5, 0, 1, 0);
    add(0, 4'h0, 0, 2, 0, 0, 0,        32'hA5, 8'hA5, 0, 1, 0);
    add(0, 4'h0, 0, 2, 0, 1, I1,       0,  8'hA5, 0, 1, 0);
    add(1, 4'h8, 0, 2, 0, 1, I2,       0,  8'hA5, 0, 1, 0);
    add(1, 4'h0, 0, 2, 0, 1, I2,       1,  8'hA5, 0, 1, 0);
    add(1, 4'hC, 1, 2, 0, 1, I2,       I1, 8'hA5, 0, 1, 0);
    add(1, 4'h8, 0, 2, 1, 1, I2,       0,  8'hA5, 0, 1, 0);
    add(0, 4'h0, 0, 2, 0, 1, I2,       2,  8'hA5, 1, 1, 0);
    add(0, 4'h0, 0, 2, 0, 0, I2,       0,  8'hA5, 1, 1, 0);
    add(0, 4'h0, 0, 2, 0, 0, I2,       0,  8'hA5, 0, 1, 0);
    add(1, 4'hC, 1, 2, 0, 0, I2,       0,  8'hA5, 0, 1, 0);
    add(1, 4'h8, 0, 2, 1, 0, I2,       0,  8'hA5, 0, 1, 0);
    add(0, 4'h0, 0, 2, 0, 0, I2,       0,  8'hA5, 0, 1, 0);
    add(1, 4'h0, 1, 2, 0, 0, I2,       0,  8'hA5, 0, 1, 0);
    add(0, 4'h0, 0, 2, 32'hDEADBEEF, 0, I2,
        0, 8'hA5, 0, E1_RDY, E1_RESP);
    add(0, 4'h0, 0, 2, 0, 0, I2,       0,  8'hA5, 0, E2_RDY, E2_RESP);
    add(1, 4'h0, 0, 2, 0, 0, I2,       0,  8'hA5, 0, 1, 0);
    add(0, 4'h0, 0, 2, 0, 0, I2,       I1, 8'hA5, 0, 1, 0);

    model_reset();
    #2;
    rst_check("reset0");
    @(posedge HCLK);
    @(posedge HCLK);
    #1 SI_Reset = 1'b0;

    foreach (tv[i]) begin
      tick(tv[i].sel, tv[i].sel ? 2'b10 : 2'b00, {28'h0, tv[i].a},
           tv[i].wr, tv[i].sz, tv[i].wd, tv[i].sync, tv[i].info, 1'b1);
      chk($sformatf("row%0d_hrdata", i), s_rdata, tv[i].e_rd);
      chk($sformatf("row%0d_ctrl", i), {24'h0, s_ctrl},
          {24'h0, tv[i].e_ctrl});
      chk($sformatf("row%0d_ack", i), {31'h0, s_ack},
          {31'h0, tv[i].e_ack});
      chk($sformatf("row%0d_rdy_resp", i), {30'h0, s_rdy, s_resp},
          {30'h0, tv[i].e_rdy, tv[i].e_resp});
    end

    // Drive into ACK, then reset asynchronously mid-cycle.
    tick(0, 2'b00, 0, 0, 2, 0, 1, 32'hCAFE_F00D, 1);
    tick(1, 2'b10, 32'hC, 1, 2, 0, 1, 0, 1);
    tick(0, 2'b00, 0, 0, 2, 1, 1, 0, 1);
    tick(0, 2'b00, 0, 0, 2, 0, 1, 0, 1);
    chk("hs_in_ack", {31'h0, s_ack}, 32'h1);
    @(negedge HCLK);
    #2 SI_Reset = 1'b1;
    IO_BotUpdt_Sync = 1'b0;
    HSEL = 1'b0; HTRANS = 2'b00;
    #1;
    rst_check("midreset");
    model_reset();
    @(posedge HCLK);
    @(posedge HCLK);
    #1 SI_Reset = 1'b0;
    tick(1, 2'b10, 32'h8, 0, 2, 0, 0, 0, 1);
    tick(0, 2'b00, 0, 0, 2, 0, 0, 0, 1);
    chk("post_reset_stat", s_rdata, 32'h0);

    // Random traffic against the model.
    r_sync = 1'b0;
    for (int k = 0; k < 800; k++) begin
      if ($urandom_range(0, 5) == 0) r_sync = ~r_sync;
      r_a = 4'($urandom);
      if ($urandom_range(0, 1) == 1) r_a[3:2] = $urandom_range(0, 1) ? 2'd1 : 2'd3;
      r_sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                         : 3'($urandom_range(0, 2));
      r_wd = $urandom;
      if ($urandom_range(0, 1) == 1) r_wd[0] = 1'b1;
      tick($urandom_range(0, 3) != 0, 2'($urandom),
           {$urandom, r_a} >> 0 & 32'hFFFF_FFFF,
           1'($urandom), r_sz, r_wd, r_sync, $urandom,
           $urandom_range(0, 7) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
